// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: memory opcodes, access
// sizes and the FSM state encoding.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } mem_op_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} msize_t;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE  = 2'd0;
  localparam lsu_state_t S_WAIT  = 2'd1;
  localparam lsu_state_t S_DONE  = 2'd2;
  localparam lsu_state_t S_DRAIN = 2'd3;

  function automatic msize_t op_size(input mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      OP_LW, OP_LWU, OP_SW: return SZ_W;
      default:              return SZ_D;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane alignment: store strobes and data placement, load data shifting
// and the final sign/zero extension of a captured load.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int NBYTES = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [3:0]        i_op,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  input  logic [XLEN-1:0]   i_captured,
  output logic [NBYTES-1:0] o_strobe,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic [XLEN-1:0]   o_result
);

  mem_op_t w_op;
  logic [NBYTES-1:0] w_mask;

  assign w_op = mem_op_t'(i_op);

  // A doubleword mask is truncated to the bus width; on a 32-bit bus that
  // access is only ever issued when misalignment trapping is disabled.
  always_comb begin
    w_mask = '0;
    case (op_size(w_op))
      SZ_B:    w_mask = NBYTES'(8'h01);
      SZ_H:    w_mask = NBYTES'(8'h03);
      SZ_W:    w_mask = NBYTES'(8'h0F);
      default: w_mask = NBYTES'(8'hFF);
    endcase
  end

  assign o_strobe = op_is_store(w_op) ? (w_mask << i_offset) : '0;
  assign o_wdata  = i_wdata << {i_offset, 3'b000};
  assign o_rdata  = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_result = '0;
    case (w_op)
      OP_LB:   o_result = XLEN'($signed(i_captured[7:0]));
      OP_LH:   o_result = XLEN'($signed(i_captured[15:0]));
      OP_LW:   o_result = XLEN'($signed(i_captured[31:0]));
      OP_LBU:  o_result = XLEN'(i_captured[7:0]);
      OP_LHU:  o_result = XLEN'(i_captured[15:0]);
      OP_LWU:  o_result = XLEN'(i_captured[31:0]);
      OP_LD:   o_result = i_captured;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: issues one data-bus request per memory
// instruction, stalls upstream until the response, and writes back the result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int ADDR_W        = 64,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  input  mem_op_t             op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [4:0]          dst,
  output logic                stall,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output msize_t              dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_data,
  output logic [4:0]          out_dst,
  output logic                out_misalign
);

  localparam int OFF_W = $clog2(XLEN / 8);

  lsu_state_t        r_state;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [4:0]        r_dst;
  logic [XLEN-1:0]   r_captured;
  logic              r_flushPending;

  logic              w_idle, w_isMem, w_misaligned, w_trap;
  logic              w_start, w_trapOut, w_passOut, w_doneOut;
  mem_op_t           w_reqOp;
  logic [ADDR_W-1:0] w_reqAddr;
  logic [XLEN-1:0]   w_reqWdata, w_rdataShifted, w_result;

  always_comb begin
    w_misaligned = 1'b0;
    case (op_size(op))
      SZ_B:    w_misaligned = 1'b0;
      SZ_H:    w_misaligned = addr[0];
      SZ_W:    w_misaligned = (addr[1:0] != 2'b00);
      default: w_misaligned = (XLEN == 32) || (addr[2:0] != 3'b000);
    endcase
  end

  assign w_idle    = (r_state == S_IDLE);
  assign w_isMem   = (op != OP_NONE);
  assign w_trap    = (MISALIGN_TRAP != 0) && w_misaligned;
  assign w_start   = !reset && w_idle && in_valid && w_isMem && !w_trap;
  assign w_trapOut = !reset && w_idle && in_valid && w_isMem && w_trap;
  assign w_passOut = !reset && w_idle && in_valid && !w_isMem;
  // A flush that arrived together with the response is remembered so the
  // completed result is still killed one cycle later.
  assign w_doneOut = !reset && (r_state == S_DONE) && !flush && !r_flushPending;

  // The request is driven straight from the inputs in the accepting cycle and
  // from the latched copy afterwards, so it stays stable while waiting.
  assign w_reqOp    = w_idle ? op    : r_op;
  assign w_reqAddr  = w_idle ? addr  : r_addr;
  assign w_reqWdata = w_idle ? wdata : r_wdata;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_op       (w_reqOp),
    .i_offset   (w_reqAddr[OFF_W-1:0]),
    .i_wdata    (w_reqWdata),
    .i_rdata    (dresp_data),
    .i_captured (r_captured),
    .o_strobe   (dreq_strobe),
    .o_wdata    (dreq_data),
    .o_rdata    (w_rdataShifted),
    .o_result   (w_result)
  );

  assign dreq_valid   = !reset && (w_start || r_state == S_WAIT || r_state == S_DRAIN);
  assign stall        = dreq_valid;
  assign dreq_addr    = w_reqAddr;
  assign dreq_size    = op_size(w_reqOp);
  assign out_valid    = w_passOut || w_trapOut || w_doneOut;
  assign out_misalign = w_trapOut;
  assign out_dst      = w_idle ? dst : r_dst;

  always_comb begin
    out_data = '0;
    if (w_passOut)
      out_data = XLEN'(addr);
    else if (w_doneOut)
      out_data = w_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= OP_NONE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_dst          <= '0;
      r_captured     <= '0;
      r_flushPending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state        <= S_WAIT;
            r_op           <= op;
            r_addr         <= addr;
            r_wdata        <= wdata;
            r_dst          <= dst;
            r_flushPending <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dresp_data_ok) begin
            r_state        <= S_DONE;
            r_captured     <= w_rdataShifted;
            r_flushPending <= flush;
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_state        <= S_IDLE;
          r_flushPending <= 1'b0;
        end
        default: begin
          if (dresp_data_ok)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized transactions
// on a 64-bit instance, and bus-width specific scenarios on a 32-bit instance.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  mem_op_t     op;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [4:0]  dst;
  logic        drespOk;
  logic [63:0] drespData;

  logic        stall64, dreqValid64, outValid64, outMisalign64;
  logic [63:0] dreqAddr64, dreqData64, outData64;
  msize_t      dreqSize64;
  logic [7:0]  dreqStrobe64;
  logic [4:0]  outDst64;

  logic        stall32, dreqValid32, outValid32, outMisalign32;
  logic [31:0] dreqAddr32, dreqData32, outData32;
  msize_t      dreqSize32;
  logic [3:0]  dreqStrobe32;
  logic [4:0]  outDst32;

  int compared;
  int mismatched;

  load_store_unit #(.XLEN(64), .ADDR_W(64), .MISALIGN_TRAP(1)) dut64 (
    .clk(clk), .reset(rst), .flush(flush), .in_valid(inValid), .op(op),
    .addr(addr), .wdata(wdata), .dst(dst), .stall(stall64),
    .dreq_valid(dreqValid64), .dreq_addr(dreqAddr64), .dreq_size(dreqSize64),
    .dreq_strobe(dreqStrobe64), .dreq_data(dreqData64),
    .dresp_data_ok(drespOk), .dresp_data(drespData),
    .out_valid(outValid64), .out_data(outData64), .out_dst(outDst64),
    .out_misalign(outMisalign64)
  );

  load_store_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_TRAP(1)) dut32 (
    .clk(clk), .reset(rst), .flush(flush), .in_valid(inValid), .op(op),
    .addr(addr[31:0]), .wdata(wdata[31:0]), .dst(dst), .stall(stall32),
    .dreq_valid(dreqValid32), .dreq_addr(dreqAddr32), .dreq_size(dreqSize32),
    .dreq_strobe(dreqStrobe32), .dreq_data(dreqData32),
    .dresp_data_ok(drespOk), .dresp_data(drespData[31:0]),
    .out_valid(outValid32), .out_data(outData32), .out_dst(outDst32),
    .out_misalign(outMisalign32)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not complete (compared=%0d)", compared);
    $fatal(1, "[TB] timeout");
  end

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic r, input logic v, input mem_op_t o,
                               input logic [63:0] a, input logic [63:0] wd,
                               input logic [4:0] d, input logic ok,
                               input logic fl, input logic [63:0] rd);
    @(negedge clk);
    rst = r; inValid = v; op = o; addr = a; wdata = wd; dst = d;
    drespOk = ok; flush = fl; drespData = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size, byte-lane placement and extension worked
  // out byte by byte from the architectural rules.
  function automatic int nBytes(input mem_op_t o);
    case (o)
      OP_NONE:             return 0;
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default:             return 8;
    endcase
  endfunction

  function automatic bit isStoreOp(input mem_op_t o);
    return o == OP_SB || o == OP_SH || o == OP_SW || o == OP_SD;
  endfunction

  function automatic bit isSignedOp(input mem_op_t o);
    return o == OP_LB || o == OP_LH || o == OP_LW;
  endfunction

  function automatic logic [63:0] modelResult(input mem_op_t o, input logic [63:0] bus,
                                              input int off);
    logic [63:0] v;
    int n;
    v = '0;
    n = nBytes(o);
    if (isStoreOp(o)) return '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bus[8*(off+i) +: 8];
    if (isSignedOp(o) && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] modelStrobe(input mem_op_t o, input int off);
    logic [63:0] s;
    s = '0;
    if (isStoreOp(o))
      for (int i = 0; i < nBytes(o); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] modelData(input logic [63:0] wd, input int off);
    logic [63:0] d;
    d = '0;
    for (int i = 0; off + i < 8; i++) d[8*(off+i) +: 8] = wd[8*i +: 8];
    return d;
  endfunction

  function automatic logic [63:0] modelSize(input int n);
    return (n == 1) ? 64'd0 : (n == 2) ? 64'd1 : (n == 4) ? 64'd2 : 64'd3;
  endfunction

  mem_op_t     rOp;
  logic [63:0] rAddr, rWd, rRd;
  logic [4:0]  rDst;
  int          rN, rOff, rWaits;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; inValid = 1'b0; op = OP_NONE; addr = '0; wdata = '0; dst = '0;
    drespOk = 1'b0; flush = 1'b0; drespData = '0;

    // Reset state and reset overriding a presented instruction.
    applyStimulus(1, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, OP_NONE, 64'h1234, 0, 5'd3, 1, 0, 0);
    checkOutput("rst_override_outValid", 64'(outValid64), 0);
    checkOutput("rst_override_dreqValid", 64'(dreqValid64), 0);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_dreqValid64", 64'(dreqValid64), 0);
    checkOutput("rst_outValid64", 64'(outValid64), 0);
    checkOutput("rst_outMisalign64", 64'(outMisalign64), 0);
    checkOutput("rst_stall64", 64'(stall64), 0);
    checkOutput("rst_dreqValid32", 64'(dreqValid32), 0);

    // NONE passes the ALU result straight through.
    applyStimulus(0, 1, OP_NONE, 64'hDEAD_BEEF_0000_1111, 0, 5'd7, 0, 0, 0);
    checkOutput("none_outValid", 64'(outValid64), 1);
    checkOutput("none_outData", outData64, 64'hDEAD_BEEF_0000_1111);
    checkOutput("none_outDst", 64'(outDst64), 7);
    checkOutput("none_stall", 64'(stall64), 0);
    checkOutput("none_dreqValid", 64'(dreqValid64), 0);

    // LW at 0x1004, response three cycles into the wait.
    applyStimulus(0, 1, OP_LW, 64'h1004, 0, 5'd3, 0, 0, 0);
    checkOutput("lw_accept_dreqValid", 64'(dreqValid64), 1);
    checkOutput("lw_accept_stall", 64'(stall64), 1);
    checkOutput("lw_accept_addr", dreqAddr64, 64'h1004);
    checkOutput("lw_accept_size", 64'(dreqSize64), 2);
    checkOutput("lw_accept_strobe", 64'(dreqStrobe64), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, OP_LW, 64'h1004, 0, 5'd3, 0, 0, 0);
      checkOutput("lw_wait_dreqValid", 64'(dreqValid64), 1);
      checkOutput("lw_wait_outValid", 64'(outValid64), 0);
    end
    applyStimulus(0, 1, OP_LW, 64'h1004, 0, 5'd3, 1, 0, 64'h8000_0000_0000_0000);
    checkOutput("lw_ok_outValid", 64'(outValid64), 0);
    applyStimulus(0, 1, OP_LW, 64'h1004, 0, 5'd3, 0, 0, 0);
    checkOutput("lw_done_outValid", 64'(outValid64), 1);
    checkOutput("lw_done_outData", outData64, 64'hFFFF_FFFF_8000_0000);
    checkOutput("lw_done_outDst", 64'(outDst64), 3);
    checkOutput("lw_done_stall", 64'(stall64), 0);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("lw_after_outValid", 64'(outValid64), 0);

    // SB at 0x2003.
    applyStimulus(0, 1, OP_SB, 64'h2003, 64'hAB, 0, 0, 0, 0);
    checkOutput("sb_strobe", 64'(dreqStrobe64), 64'h08);
    checkOutput("sb_data", dreqData64, 64'hAB00_0000);
    applyStimulus(0, 1, OP_SB, 64'h2003, 64'hAB, 0, 1, 0, 64'h5555_5555_5555_5555);
    checkOutput("sb_hold_strobe", 64'(dreqStrobe64), 64'h08);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_done_outValid", 64'(outValid64), 1);
    checkOutput("sb_done_outData", outData64, 0);

    // Misaligned LH.
    applyStimulus(0, 1, OP_LH, 64'h3001, 0, 0, 0, 0, 0);
    checkOutput("lh_mis_dreqValid", 64'(dreqValid64), 0);
    checkOutput("lh_mis_outValid", 64'(outValid64), 1);
    checkOutput("lh_mis_outMisalign", 64'(outMisalign64), 1);
    checkOutput("lh_mis_stall", 64'(stall64), 0);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("lh_mis_after", 64'(outMisalign64), 0);

    // Flush while waiting: request held until the response is drained.
    applyStimulus(0, 1, OP_LD, 64'h5000, 0, 5'd1, 0, 0, 0);
    applyStimulus(0, 1, OP_LD, 64'h5000, 0, 5'd1, 0, 1, 0);
    checkOutput("flush_dreqValid", 64'(dreqValid64), 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
      checkOutput("drain_dreqValid", 64'(dreqValid64), 1);
      checkOutput("drain_stall", 64'(stall64), 1);
      checkOutput("drain_outValid", 64'(outValid64), 0);
      checkOutput("drain_addr", dreqAddr64, 64'h5000);
    end
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("drain_ok_dreqValid", 64'(dreqValid64), 1);
    checkOutput("drain_ok_outValid", 64'(outValid64), 0);
    applyStimulus(0, 1, OP_LD, 64'h5008, 0, 5'd9, 0, 0, 0);
    checkOutput("next_ld_dreqValid", 64'(dreqValid64), 1);
    checkOutput("next_ld_addr", dreqAddr64, 64'h5008);
    checkOutput("next_ld_outValid", 64'(outValid64), 0);
    applyStimulus(0, 1, OP_LD, 64'h5008, 0, 5'd9, 1, 0, 64'h0123_4567_89AB_CDEF);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("next_ld_outValid_done", 64'(outValid64), 1);
    checkOutput("next_ld_outData", outData64, 64'h0123_4567_89AB_CDEF);
    checkOutput("next_ld_outDst", 64'(outDst64), 9);

    // Response and flush in the same waiting cycle.
    applyStimulus(0, 1, OP_LW, 64'h6000, 0, 5'd2, 0, 0, 0);
    applyStimulus(0, 1, OP_LW, 64'h6000, 0, 5'd2, 1, 1, 64'h1234);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("okflush_outValid", 64'(outValid64), 0);
    checkOutput("okflush_stall", 64'(stall64), 0);
    applyStimulus(0, 1, OP_NONE, 64'h77, 0, 0, 0, 0, 0);
    checkOutput("okflush_idle_outValid", 64'(outValid64), 1);
    checkOutput("okflush_idle_outData", outData64, 64'h77);

    // Randomized transactions against the byte-level model.
    for (int t = 0; t < 40; t++) begin
      rOp = mem_op_t'($urandom_range(0, 11));
      rN = nBytes(rOp);
      rAddr = {$urandom, $urandom};
      if (rN > 0 && $urandom_range(0, 3) != 0) rAddr = rAddr & ~64'(rN - 1);
      rWd = {$urandom, $urandom};
      rRd = {$urandom, $urandom};
      rDst = 5'($urandom);
      rWaits = $urandom_range(0, 3);
      rOff = int'(rAddr[2:0]);
      applyStimulus(0, 1, rOp, rAddr, rWd, rDst, 0, 0, 0);
      if (rN == 0) begin
        checkOutput("rnd_none_outValid", 64'(outValid64), 1);
        checkOutput("rnd_none_outData", outData64, rAddr);
        checkOutput("rnd_none_outDst", 64'(outDst64), 64'(rDst));
        checkOutput("rnd_none_dreqValid", 64'(dreqValid64), 0);
      end else if ((rAddr & 64'(rN - 1)) != 0) begin
        checkOutput("rnd_mis_dreqValid", 64'(dreqValid64), 0);
        checkOutput("rnd_mis_outMisalign", 64'(outMisalign64), 1);
        checkOutput("rnd_mis_outValid", 64'(outValid64), 1);
        checkOutput("rnd_mis_stall", 64'(stall64), 0);
      end else begin
        checkOutput("rnd_dreqValid", 64'(dreqValid64), 1);
        checkOutput("rnd_stall", 64'(stall64), 1);
        checkOutput("rnd_addr", dreqAddr64, rAddr);
        checkOutput("rnd_size", 64'(dreqSize64), modelSize(rN));
        checkOutput("rnd_strobe", 64'(dreqStrobe64), modelStrobe(rOp, rOff));
        checkOutput("rnd_data", dreqData64, modelData(rWd, rOff));
        checkOutput("rnd_outValid_accept", 64'(outValid64), 0);
        for (int w = 0; w < rWaits; w++) begin
          applyStimulus(0, 1, rOp, rAddr, rWd, rDst, 0, 0, 0);
          checkOutput("rnd_wait_dreqValid", 64'(dreqValid64), 1);
          checkOutput("rnd_wait_strobe", 64'(dreqStrobe64), modelStrobe(rOp, rOff));
          checkOutput("rnd_wait_outValid", 64'(outValid64), 0);
        end
        applyStimulus(0, 1, rOp, rAddr, rWd, rDst, 1, 0, rRd);
        checkOutput("rnd_ok_dreqValid", 64'(dreqValid64), 1);
        applyStimulus(0, 1, rOp, rAddr, rWd, rDst, 0, 0, 0);
        checkOutput("rnd_done_outValid", 64'(outValid64), 1);
        checkOutput("rnd_done_outData", outData64, modelResult(rOp, rRd, rOff));
        checkOutput("rnd_done_outDst", 64'(outDst64), 64'(rDst));
        checkOutput("rnd_done_stall", 64'(stall64), 0);
        checkOutput("rnd_done_outMisalign", 64'(outMisalign64), 0);
      end
      applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
      checkOutput("rnd_gap_dreqValid", 64'(dreqValid64), 0);
    end

    // 32-bit bus: LBU at 0x4002.
    applyStimulus(1, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, OP_LBU, 64'h4002, 0, 5'd4, 0, 0, 0);
    checkOutput("x32_lbu_dreqValid", 64'(dreqValid32), 1);
    checkOutput("x32_lbu_strobe", 64'(dreqStrobe32), 0);
    applyStimulus(0, 1, OP_LBU, 64'h4002, 0, 5'd4, 1, 0, 64'h0000_0000_00F0_0000);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("x32_lbu_outValid", 64'(outValid32), 1);
    checkOutput("x32_lbu_outData", 64'(outData32), 64'h0000_00F0);
    checkOutput("x32_lbu_outDst", 64'(outDst32), 4);
    checkOutput("x64_lbu_outData", outData64, 64'h0000_00F0);

    // 32-bit bus: any doubleword access is reported as misaligned.
    applyStimulus(0, 1, OP_LD, 64'h4000, 0, 0, 0, 0, 0);
    checkOutput("x32_ld_outMisalign", 64'(outMisalign32), 1);
    checkOutput("x32_ld_dreqValid", 64'(dreqValid32), 0);
    checkOutput("x64_ld_dreqValid", 64'(dreqValid64), 1);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);

    // Reset while waiting drops the request at once.
    applyStimulus(0, 1, OP_LW, 64'h4000, 64'h5555_AAAA, 0, 0, 0, 0);
    checkOutput("x32_lw_dreqValid", 64'(dreqValid32), 1);
    checkOutput("x32_lw_addr", 64'(dreqAddr32), 64'h4000);
    checkOutput("x32_lw_size", 64'(dreqSize32), 2);
    checkOutput("x32_lw_data", 64'(dreqData32), 64'h5555_AAAA);
    applyStimulus(1, 1, OP_LW, 64'h4000, 0, 0, 0, 0, 0);
    checkOutput("x32_rstwait_dreqValid", 64'(dreqValid32), 0);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("x32_afterrst_dreqValid", 64'(dreqValid32), 0);
    checkOutput("x32_afterrst_stall", 64'(stall32), 0);
    checkOutput("x64_afterrst_dreqValid", 64'(dreqValid64), 0);

    // A response arriving in the accepting cycle is ignored.
    applyStimulus(0, 1, OP_LW, 64'h4004, 0, 5'd6, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(0, 1, OP_LW, 64'h4004, 0, 5'd6, 0, 0, 0);
    checkOutput("x32_stray_ok_dreqValid", 64'(dreqValid32), 1);
    checkOutput("x32_stray_ok_outValid", 64'(outValid32), 0);
    applyStimulus(0, 1, OP_LW, 64'h4004, 0, 5'd6, 1, 0, 64'h1111_2222_8765_4321);
    applyStimulus(0, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
    checkOutput("x32_lw_outValid", 64'(outValid32), 1);
    checkOutput("x32_lw_outData", 64'(outData32), 64'h8765_4321);
    checkOutput("x64_lw_outData", outData64, 64'h1111_2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
